// File: rtl/pow_unit_param.sv
// ---------------------------------------------------------------------------
// pow_unit_param
//   Sequential integer power engine: out = inx ** inn mod 2**WIDTH, computed by
//   right-to-left binary exponentiation over one shared WIDTH x WIDTH
//   multiplier (one multiply per BUSY cycle).
//
//   Handshake: start is accepted while ready=1; abort cancels while ready=0.
//   done pulses for one cycle when out takes a completed result.
//
//   Optional build macro:
//     POW_UNIT_OVERFLOW_FLAG_EN - adds the overflow output, which reports
//                                 whether the true x**n reached 2**WIDTH for
//                                 the last completed result.
// ---------------------------------------------------------------------------
module pow_unit_param #(
   parameter int WIDTH     = 16,
   parameter int EXP_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [WIDTH-1:0]     inx,
   input  logic [EXP_WIDTH-1:0] inn,
   output logic                 ready,
   output logic                 done,
   output logic [WIDTH-1:0]     out
`ifdef POW_UNIT_OVERFLOW_FLAG_EN
   ,
   output logic                 overflow
`endif
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t               state, state_nxt;

   // Working registers: acc collects the result, base holds x^(2^k), e is the
   // not-yet-consumed part of the exponent.
   logic [WIDTH-1:0]     acc, acc_nxt;
   logic [WIDTH-1:0]     base, base_nxt;
   logic [EXP_WIDTH-1:0] e, e_nxt;
   logic [WIDTH-1:0]     out_nxt;
   logic                 done_nxt;

   // Shared multiplier: multiplicand is acc on a multiply step, base on a
   // squaring step; the other operand is always base.
   logic [WIDTH-1:0]     mul_a;
   logic [2*WIDTH-1:0]   product;
   logic                 product_hi_nz;

`ifdef POW_UNIT_OVERFLOW_FLAG_EN
   logic                 ovf, ovf_nxt;
   logic                 overflow_nxt;
`endif

   // Operand select and full-width product; only the low half is kept.
   always_comb begin
      mul_a         = e[0] ? acc : base;
      product       = {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, base};
      product_hi_nz = |product[2*WIDTH-1:WIDTH];
   end

   // ready is a pure decode of the state, so it rises on the same edge that
   // returns the FSM to IDLE.
   assign ready = (state == S_IDLE);

   // Next-state and datapath update; every BUSY cycle does exactly one action.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      state_nxt = state;
      acc_nxt   = acc;
      base_nxt  = base;
      e_nxt     = e;
      out_nxt   = out;
      done_nxt  = 1'b0;
`ifdef POW_UNIT_OVERFLOW_FLAG_EN
      ovf_nxt      = ovf;
      overflow_nxt = overflow;
`endif

      case (state)
         S_IDLE: begin
            // abort is meaningless here; start wins outright.
            if (start) begin
               acc_nxt   = WIDTH'(1);
               base_nxt  = inx;
               e_nxt     = inn;
               state_nxt = S_BUSY;
`ifdef POW_UNIT_OVERFLOW_FLAG_EN
               ovf_nxt   = 1'b0;
`endif
            end
         end

         S_BUSY: begin
            if (abort) begin
               // Drop the operation; out/overflow keep the previous result.
               state_nxt = S_IDLE;
            end else if (e == '0) begin
               out_nxt   = acc;
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
`ifdef POW_UNIT_OVERFLOW_FLAG_EN
               overflow_nxt = ovf;
`endif
            end else if (e[0]) begin
               // Fold the current base power into the result, consume the bit.
               acc_nxt = product[WIDTH-1:0];
               e_nxt   = e & ~EXP_WIDTH'(1);
`ifdef POW_UNIT_OVERFLOW_FLAG_EN
               ovf_nxt = ovf | product_hi_nz;
`endif
            end else begin
               // Advance base to the next power of two, shift the exponent.
               // Every squared base is later multiplied into acc, so a wrap
               // here always implies the true result wraps too.
               base_nxt = product[WIDTH-1:0];
               e_nxt    = e >> 1;
`ifdef POW_UNIT_OVERFLOW_FLAG_EN
               ovf_nxt  = ovf | product_hi_nz;
`endif
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state <= S_IDLE;
         acc   <= '0;
         base  <= '0;
         e     <= '0;
         out   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         base  <= base_nxt;
         e     <= e_nxt;
         out   <= out_nxt;
         done  <= done_nxt;
      end
   end

`ifdef POW_UNIT_OVERFLOW_FLAG_EN
   // Sticky overflow tracker and the flag published with each result.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf      <= 1'b0;
         overflow <= 1'b0;
      end else begin
         ovf      <= ovf_nxt;
         overflow <= overflow_nxt;
      end
   end
`else
   // Without the flag the upper product half is simply discarded.
   logic unused_product_hi;
   assign unused_product_hi = product_hi_nz;
`endif

endmodule
